// File: rtl/regfile_write_arbiter.sv
// Shares the single RF write port: writeback first, then a 2-deep in-order lu buffer, then lu bypass.
// wb/bypass write in 0 cycles, buffered lu in >=1 cycle; lu backpressured when full, stall_req forces drain.
module regfile_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            lu_valid,
    input  logic [AW-1:0]   lu_rd,
    input  logic [XLEN-1:0] lu_data,
    output logic            lu_ready,
    output logic            rf_en,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_data,
    input  logic [AW-1:0]   rs1_address,
    input  logic [AW-1:0]   rs2_address,
    output logic            rs1_pending,
    output logic            rs2_pending,
    output logic            stall_req,
    output logic            proto_err
);
    localparam int AGE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT - 1);

    logic [1:0]       count_q, count_d;
    logic             head_q, head_d, tail_q, tail_d;
    logic [AW-1:0]    ent_rd_q   [2];
    logic [XLEN-1:0]  ent_data_q [2];
    logic [AGE_W-1:0] age_q, age_d;
    logic             stall_q, stall_d;
    logic             perr_q, perr_d;

    logic wb_req, lu_live, deq, bypass, enq, head_denied;
    logic [1:0] ent_vld;

    assign wb_req      = wb_valid && (wb_rd != '0);
    assign lu_ready    = rst_n && (count_q != 2'd2);
    assign lu_live     = lu_valid && lu_ready && (lu_rd != '0);
    assign deq         = !wb_req && (count_q != 2'd0);
    assign bypass      = !wb_req && (count_q == 2'd0) && lu_live;
    assign enq         = lu_live && !bypass;
    assign head_denied = wb_req && (count_q != 2'd0);

    // Only the head is valid at count 1, so its slot depends on head_q.
    assign ent_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && !head_q);
    assign ent_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && head_q);

    assign rs1_pending = rst_n && (rs1_address != '0) &&
        ((ent_vld[0] && (ent_rd_q[0] == rs1_address)) || (ent_vld[1] && (ent_rd_q[1] == rs1_address)));
    assign rs2_pending = rst_n && (rs2_address != '0) &&
        ((ent_vld[0] && (ent_rd_q[0] == rs2_address)) || (ent_vld[1] && (ent_rd_q[1] == rs2_address)));

    assign stall_req = stall_q;
    assign proto_err = perr_q;

    always_comb begin
        rf_en   = 1'b0;
        rf_rd   = '0;
        rf_data = '0;
        if (rst_n) begin
            if (wb_req) begin
                rf_en   = 1'b1;
                rf_rd   = wb_rd;
                rf_data = wb_data;
            end else if (deq) begin
                rf_en   = 1'b1;
                rf_rd   = ent_rd_q[head_q];
                rf_data = ent_data_q[head_q];
            end else if (bypass) begin
                rf_en   = 1'b1;
                rf_rd   = lu_rd;
                rf_data = lu_data;
            end
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, enq} - {1'b0, deq};
        head_d  = deq ? ~head_q : head_q;
        tail_d  = enq ? ~tail_q : tail_q;

        age_d = age_q;
        if (deq || (count_q == 2'd0))
            age_d = '0;
        else if (head_denied && (age_q != AGE_MAX))
            age_d = age_q + 1'b1;

        // A set (head still denied) can never coincide with the drain completing.
        stall_d = stall_q;
        if (head_denied && (age_q == AGE_MAX))
            stall_d = 1'b1;
        else if (count_d == 2'd0)
            stall_d = 1'b0;

        perr_d = perr_q || (wb_valid && stall_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q       <= '0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            age_q         <= '0;
            stall_q       <= 1'b0;
            perr_q        <= 1'b0;
            ent_rd_q[0]   <= '0;
            ent_rd_q[1]   <= '0;
            ent_data_q[0] <= '0;
            ent_data_q[1] <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            age_q   <= age_d;
            stall_q <= stall_d;
            perr_q  <= perr_d;
            if (enq) begin
                ent_rd_q[tail_q]   <= lu_rd;
                ent_data_q[tail_q] <= lu_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid, lu_valid;
    logic [4:0]  wb_rd, lu_rd, rs1_address, rs2_address;
    logic [31:0] wb_data, lu_data;
    logic        lu_ready, rf_en, rs1_pending, rs2_pending, stall_req, proto_err;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(.XLEN(32), .AW(5), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .rf_en(rf_en), .rf_rd(rf_rd), .rf_data(rf_data),
        .rs1_address(rs1_address), .rs2_address(rs2_address),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
        .stall_req(stall_req), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v; wb_rd = rd; wb_data = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v; lu_rd = rd; lu_data = d;
    endtask

    task automatic expect_write(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        check_eq({tag, ".en"},   32'(rf_en), 32'(en));
        check_eq({tag, ".rd"},   32'(rf_rd), 32'(rd));
        check_eq({tag, ".data"}, rf_data,    d);
    endtask

    initial begin
        rst_n = 1'b0;
        wb(1'b1, 5'd3, 32'h1234); lu(1'b0, 5'd0, 32'h0);
        rs1_address = 5'd0; rs2_address = 5'd0;
        #2;
        check_eq("rst.rf_en",    32'(rf_en),     32'd0);
        check_eq("rst.lu_ready", 32'(lu_ready),  32'd0);
        check_eq("rst.stall",    32'(stall_req), 32'd0);
        check_eq("rst.perr",     32'(proto_err), 32'd0);
        wb(1'b0, 5'd0, 32'h0);
        #10 rst_n = 1'b1;
        #1;
        check_eq("rel.lu_ready", 32'(lu_ready), 32'd1);
        tick();

        // writeback only, then rd=0 ignored
        wb(1'b1, 5'd3, 32'hDEADBEEF); #1;
        expect_write("wb", 1'b1, 5'd3, 32'hDEADBEEF);
        tick();
        wb(1'b1, 5'd0, 32'hCAFEF00D); #1;
        expect_write("wb0", 1'b0, 5'd0, 32'h0);
        tick();

        // collision: wb wins, lu buffered then drained
        wb(1'b1, 5'd4, 32'h44); lu(1'b1, 5'd7, 32'h11); rs1_address = 5'd7; #1;
        expect_write("col", 1'b1, 5'd4, 32'h44);
        check_eq("col.same_cyc_pend", 32'(rs1_pending), 32'd0);
        tick();
        wb(1'b0, 5'd0, 32'h0); lu(1'b0, 5'd0, 32'h0); #1;
        check_eq("col.pend", 32'(rs1_pending), 32'd1);
        expect_write("col.drain", 1'b1, 5'd7, 32'h11);
        tick();
        check_eq("col.pend_clr", 32'(rs1_pending), 32'd0);
        check_eq("col.idle_en",  32'(rf_en),       32'd0);

        // fill both entries under continuous writeback
        wb(1'b1, 5'd1, 32'h1); lu(1'b1, 5'd5, 32'h55);
        tick();
        lu(1'b1, 5'd6, 32'h66); #1;
        check_eq("full.rdy_cnt1", 32'(lu_ready), 32'd1);
        tick();
        lu(1'b0, 5'd0, 32'h0); rs1_address = 5'd5; rs2_address = 5'd6; #1;
        check_eq("full.rdy",   32'(lu_ready),    32'd0);
        check_eq("full.pend1", 32'(rs1_pending), 32'd1);
        check_eq("full.pend2", 32'(rs2_pending), 32'd1);
        tick();
        wb(1'b0, 5'd0, 32'h0); lu(1'b1, 5'd8, 32'h88); #1;
        expect_write("full.d0", 1'b1, 5'd5, 32'h55);
        check_eq("full.rdy_deq", 32'(lu_ready),  32'd0);
        check_eq("full.nostall", 32'(stall_req), 32'd0);
        tick();
        lu(1'b0, 5'd0, 32'h0); #1;
        expect_write("full.d1", 1'b1, 5'd6, 32'h66);
        check_eq("full.rdy_back", 32'(lu_ready), 32'd1);
        tick();
        check_eq("full.no_refill", 32'(rf_en), 32'd0);

        // starvation: head denied 4 cycles raises stall_req
        wb(1'b1, 5'd2, 32'h2); lu(1'b1, 5'd10, 32'hAA);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_eq($sformatf("starve.c%0d", i), 32'(stall_req), 32'd0);
            tick();
        end
        check_eq("starve.stall",  32'(stall_req), 32'd1);
        check_eq("starve.perr0",  32'(proto_err), 32'd0);
        expect_write("starve.wbwin", 1'b1, 5'd2, 32'h2);
        tick();
        check_eq("starve.perr1",  32'(proto_err), 32'd1);
        check_eq("starve.hold",   32'(stall_req), 32'd1);
        wb(1'b0, 5'd0, 32'h0); #1;
        expect_write("starve.drain", 1'b1, 5'd10, 32'hAA);
        tick();
        check_eq("starve.clr",    32'(stall_req), 32'd0);
        check_eq("starve.sticky", 32'(proto_err), 32'd1);

        // discard rd=0, then bypass
        lu(1'b1, 5'd0, 32'hBAD); #1;
        check_eq("disc.en",  32'(rf_en),    32'd0);
        check_eq("disc.rdy", 32'(lu_ready), 32'd1);
        tick();
        lu(1'b1, 5'd9, 32'h99); #1;
        expect_write("byp", 1'b1, 5'd9, 32'h99);
        tick();
        lu(1'b0, 5'd0, 32'h0); #1;
        check_eq("byp.not_buffered", 32'(rf_en), 32'd0);
        tick();

        // reset while full and stalled
        wb(1'b1, 5'd1, 32'h1); lu(1'b1, 5'd5, 32'h55);
        tick();
        lu(1'b1, 5'd6, 32'h66);
        tick();
        lu(1'b0, 5'd0, 32'h0);
        tick(); tick(); tick();
        check_eq("rmid.stall", 32'(stall_req), 32'd1);
        check_eq("rmid.full",  32'(lu_ready),  32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rmid.en",    32'(rf_en),       32'd0);
        check_eq("rmid.rdy",   32'(lu_ready),    32'd0);
        check_eq("rmid.stall0",32'(stall_req),   32'd0);
        check_eq("rmid.perr0", 32'(proto_err),   32'd0);
        check_eq("rmid.pend",  32'(rs1_pending), 32'd0);
        wb(1'b0, 5'd0, 32'h0);
        tick();
        rst_n = 1'b1; #1;
        check_eq("rrel.rdy",  32'(lu_ready),    32'd1);
        check_eq("rrel.en",   32'(rf_en),       32'd0);
        check_eq("rrel.pend", 32'(rs1_pending), 32'd0);
        tick();
        check_eq("rrel.stale", 32'(rf_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order writeback stage and the long-latency unit (load/multiply-divide) response path. Writeback always has priority. Displaced long-latency results wait in a 2-entry in-order buffer, and a starvation limit forces a pipeline bubble so they drain. The block also reports which source registers have buffered, not-yet-written results, for the hazard unit in decode.

## Interface
Parameters:
- XLEN, 32, data width
- AW, 5, register address width
- STARVE_LIMIT, 4, consecutive denied cycles of buffer head before stall_req (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback stage has a result this cycle (cannot be back-pressured)
- wb_rd  in  AW  writeback destination
- wb_data  in  XLEN  writeback value
- lu_valid  in  1  long-latency result offered
- lu_rd  in  AW  its destination
- lu_data  in  XLEN  its value
- lu_ready  out  1  arbiter accepts lu result this cycle
- rf_en  out  1  register file write enable
- rf_rd  out  AW  register file write address
- rf_data  out  XLEN  register file write data
- rs1_address  in  AW  decode source 1
- rs2_address  in  AW  decode source 2
- rs1_pending  out  1  rs1 matches a buffered entry
- rs2_pending  out  1  rs2 matches a buffered entry
- stall_req  out  1  pipeline must present wb_valid=0 while high
- proto_err  out  1  sticky; wb_valid seen while stall_req high

## Operation
- Requests:
  - wb request = wb_valid & (wb_rd≠0).
  - wb_valid with wb_rd=0 is ignored and does not take the port.
- lu handshake occurs when lu_valid & lu_ready.
  - lu_ready = (count<2), registered count.
  - lu handshake with lu_rd=0 is consumed and discarded: never written, never buffered.
- Buffer: 2-entry FIFO {rd, data}, state count ∈ {0,1,2}, head/tail pointers wrap mod 2.
- Port grant priority each cycle:
  1. wb request → rf_en=1, rf_rd=wb_rd, rf_data=wb_data.
  2. Otherwise, if count>0 → write head entry, dequeue.
  3. Otherwise, if lu handshake with lu_rd≠0 → write lu directly (bypass, not enqueued).
  4. Otherwise rf_en=0 and rf_rd/rf_data=0.
- Enqueue:
  - A lu handshake (rd≠0) that is not bypassed is enqueued at tail.
  - Simultaneous dequeue and enqueue leaves count unchanged.
- rs*_pending = OR over valid entries of (entry.rd == rs*_address), with rs*_address≠0. Same-cycle lu inputs are not included.
- Starvation:
  - age counter counts consecutive cycles the head is valid and not granted.
  - age resets to 0 on dequeue or when count=0.
  - When head is denied and age = STARVE_LIMIT−1, stall_req is set next cycle.
  - stall_req stays high until count=0 at a clock edge, then clears.
- If wb_valid=1 while stall_req=1: wb still wins and proto_err is set (cleared only by reset).
- Ordering: buffered entries are written oldest first. WAW/RAW against buffered rd is the hazard unit's job, using rs*_pending.

## Timing
- Write path is combinational: the rf_* outputs reflect the grant in the same cycle. The register file commits on the next rising clk edge.
- Latency:
  - wb: 0 cycles to rf_en.
  - lu bypass: 0 cycles.
  - buffered lu: ≥1 cycle.
- count, pointers, age, stall_req and proto_err are registered.
- lu_ready and rs*_pending change only after clock edges, except rs*_pending's dependence on rs*_address.
- Reset (rst_n low, any time, including mid-drain):
  - FIFO is emptied with contents dropped; count=0, age=0.
  - stall_req=0, proto_err=0.
  - rf_en, lu_ready and rs*_pending are forced 0 while rst_n is low.
  - lu_ready is 1 in the first cycle after release.
- Full boundary: at count=2, lu_ready=0 even if a dequeue happens that cycle; no same-cycle refill.
- Worst-case drain with stall honoured: 2 cycles.

## Test plan
- wb only: wb_valid=1, rd=3, data=0xDEADBEEF → same cycle rf_en=1, rf_rd=3, rf_data=0xDEADBEEF. wb_rd=0 → rf_en=0.
- Collision: wb rd=4 and lu rd=7/0x11 in the same cycle → rd=4 written, count=1, rs1_address=7 gives rs1_pending=1. Next cycle with no wb → rd=7/0x11 written, count=0, rs1_pending=0.
- Full: wb_valid held high every cycle, two lu handshakes (rd=5, rd=6) → count=2, lu_ready=0. Dropping wb → rd=5 then rd=6 written in order, lu_ready returns to 1.
- Starvation (STARVE_LIMIT=4): one buffered entry, wb held 4 cycles → stall_req high in cycle 5. Bench drops wb → entry written, stall_req low the following cycle. Keeping wb high during stall → proto_err=1, sticky.
- Discard and bypass: lu rd=0 handshake → no write, count stays 0. lu rd=9 with idle wb and empty FIFO → written the same cycle.
- Reset mid-operation: count=2, stall_req=1, assert rst_n=0 between edges → outputs immediately 0. After release, count=0 and lu_ready=1; no stale writes appear.
